pipelined_shifter: RTL and testbench

Parametrised, pipelined successor to the ALU's combinational right-shift unit. It performs logical left, logical right, arithmetic right and rotate right on a WIDTH-bit operand, with one pipeline stage per shift-amount bit and a valid/ready handshake on both sides. It sits between the ALU operand mux and the ALU result mux. It replaces the fixed 2-time-unit-delay shifter with a clocked, back-pressurable datapath.

---
 rtl/shift_pkg.sv | 22 ++
 rtl/shift_stage.sv | 58 +++++
 rtl/pipelined_shifter.sv | 91 +++++++++
 tb/tb_pipelined_shifter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types for the pipelined shifter: mode encodings and the per-stage record
// that travels down the pipeline alongside the partially shifted operand.
package shift_pkg;

    localparam int MAX_WIDTH   = 64;
    localparam int MAX_SHAMT_W = 6;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    // Sized for the widest supported operand; narrower instances use the low bits only.
    typedef struct packed {
        logic [MAX_WIDTH-1:0]   data;
        logic                   sign;
        logic [1:0]             mode;
        logic [MAX_SHAMT_W-1:0] shamt;
        logic                   valid;
    } shift_rec_t;

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage: conditionally shifts by 2**STAGE positions according to the
// operation mode, then registers the record with hold (stall) and flush control.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STAGE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       stall,
    input  shift_rec_t in_rec,
    output shift_rec_t out_rec
);

    localparam int STEP = 1 << STAGE;

    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] shifted;
    shift_rec_t       rec_d;
    shift_rec_t       rec_q;

    // SRA fills from the carried original sign, not the current MSB.
    always_comb begin
        din     = in_rec.data[WIDTH-1:0];
        shifted = din;
        if (in_rec.shamt[STAGE]) begin
            unique case (in_rec.mode)
                MODE_SLL: shifted = din << STEP;
                MODE_SRL: shifted = din >> STEP;
                MODE_SRA: shifted = {{STEP{in_rec.sign}}, din[WIDTH-1:STEP]};
                MODE_ROR: shifted = {din[STEP-1:0], din[WIDTH-1:STEP]};
            endcase
        end
    end

    always_comb begin
        rec_d = rec_q;
        if (flush) begin
            rec_d.valid = 1'b0;
        end else if (!stall) begin
            rec_d                   = in_rec;
            rec_d.data[WIDTH-1:0]   = shifted;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rec_q <= '0;
        end else begin
            rec_q <= rec_d;
        end
    end

    assign out_rec = rec_q;

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with one stage per shift-amount bit,
// a global stall driven by output back-pressure, and a synchronous flush.
module pipelined_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               FLUSH,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [WIDTH-1:0]   DATA_IN,
    input  logic [SHAMT_W-1:0] SHAMT,
    input  logic [1:0]         MODE,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [WIDTH-1:0]   DATA_OUT,
    output logic               BUSY
);

    shift_rec_t in_rec;
    shift_rec_t stage_q [SHAMT_W];
    logic       stall;
    logic       busy_d;
    logic       busy_q;
    logic       unused_tail;

    always_comb begin
        in_rec                      = '0;
        in_rec.data[WIDTH-1:0]      = DATA_IN;
        in_rec.sign                 = DATA_IN[WIDTH-1];
        in_rec.mode                 = MODE;
        in_rec.shamt[SHAMT_W-1:0]   = SHAMT;
        in_rec.valid                = IN_VALID;
    end

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        shift_rec_t stage_in;
        if (k == 0) begin : g_first
            assign stage_in = in_rec;
        end else begin : g_next
            assign stage_in = stage_q[k-1];
        end

        shift_stage #(
            .WIDTH (WIDTH),
            .STAGE (k)
        ) u_stage (
            .clk     (CLK),
            .rst     (RESET),
            .flush   (FLUSH),
            .stall   (stall),
            .in_rec  (stage_in),
            .out_rec (stage_q[k])
        );
    end

    assign OUT_VALID = stage_q[SHAMT_W-1].valid;
    assign DATA_OUT  = stage_q[SHAMT_W-1].data[WIDTH-1:0];
    assign stall     = OUT_VALID && !OUT_READY;
    assign IN_READY  = !stall;

    // BUSY is registered: predict the OR of the stage valid bits after this edge.
    always_comb begin
        busy_d = 1'b0;
        if (!FLUSH) begin
            busy_d = stall ? 1'b0 : IN_VALID;
            for (int k = 0; k < SHAMT_W; k++) begin
                if (stall || k < SHAMT_W - 1) begin
                    busy_d = busy_d | stage_q[k].valid;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign BUSY = busy_q;

    assign unused_tail = ^{stage_q[SHAMT_W-1].sign, stage_q[SHAMT_W-1].mode,
                           stage_q[SHAMT_W-1].shamt, stage_q[SHAMT_W-1].data};

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed self-checking bench for pipelined_shifter: an 8-bit instance for the
// main scenarios and a 32-bit instance for the wide rotate after async reset.
module tb_pipelined_shifter;

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    logic        clk = 1'b0;
    logic        reset;

    logic        flush8, in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [7:0]  data_in8, data_out8;
    logic [2:0]  shamt8;
    logic [1:0]  mode8;

    logic        flush32, in_valid32, in_ready32, out_valid32, out_ready32, busy32;
    logic [31:0] data_in32, data_out32;
    logic [4:0]  shamt32;
    logic [1:0]  mode32;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipelined_shifter #(.WIDTH(8)) u_dut8 (
        .CLK(clk), .RESET(reset), .FLUSH(flush8), .IN_VALID(in_valid8), .IN_READY(in_ready8),
        .DATA_IN(data_in8), .SHAMT(shamt8), .MODE(mode8), .OUT_VALID(out_valid8),
        .OUT_READY(out_ready8), .DATA_OUT(data_out8), .BUSY(busy8)
    );

    pipelined_shifter #(.WIDTH(32)) u_dut32 (
        .CLK(clk), .RESET(reset), .FLUSH(flush32), .IN_VALID(in_valid32), .IN_READY(in_ready32),
        .DATA_IN(data_in32), .SHAMT(shamt32), .MODE(mode32), .OUT_VALID(out_valid32),
        .OUT_READY(out_ready32), .DATA_OUT(data_out32), .BUSY(busy32)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic v, input logic [7:0] d, input logic [2:0] s, input logic [1:0] m);
        in_valid8 = v;
        data_in8  = d;
        shamt8    = s;
        mode8     = m;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush8 = 1'b0; out_ready8 = 1'b1; drive8(1'b0, 8'h00, 3'd0, SLL);
        flush32 = 1'b0; out_ready32 = 1'b1; in_valid32 = 1'b0; data_in32 = '0; shamt32 = '0; mode32 = SLL;
        step();
        vectors++; if (out_valid8 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset out_valid8: got %b expected 0", out_valid8); end
        vectors++; if (data_out8 !== 8'h00) begin miscompares++; $display("[TB] FAIL reset data_out8: got %h expected 00", data_out8); end
        vectors++; if (busy8 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset busy8: got %b expected 0", busy8); end
        vectors++; if (in_ready8 !== 1'b1) begin miscompares++; $display("[TB] FAIL reset in_ready8: got %b expected 1", in_ready8); end
        vectors++; if (out_valid32 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset out_valid32: got %b expected 0", out_valid32); end
        vectors++; if (data_out32 !== 32'h0) begin miscompares++; $display("[TB] FAIL reset data_out32: got %h expected 00000000", data_out32); end
        vectors++; if (busy32 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset busy32: got %b expected 0", busy32); end
        step();
        reset = 1'b0;
    endtask

    task automatic test_ror();
        drive8(1'b1, 8'b11000011, 3'd3, ROR);
        step();
        drive8(1'b0, 8'h00, 3'd0, SLL);
        vectors++; if (out_valid8 !== 1'b0) begin miscompares++; $display("[TB] FAIL ror early valid (edge 1): got %b expected 0", out_valid8); end
        step();
        vectors++; if (out_valid8 !== 1'b0) begin miscompares++; $display("[TB] FAIL ror early valid (edge 2): got %b expected 0", out_valid8); end
        step();
        vectors++; if (out_valid8 !== 1'b1) begin miscompares++; $display("[TB] FAIL ror valid: got %b expected 1", out_valid8); end
        vectors++; if (data_out8 !== 8'b01111000) begin miscompares++; $display("[TB] FAIL ror data: got %b expected 01111000", data_out8); end
        step();
        vectors++; if (out_valid8 !== 1'b0) begin miscompares++; $display("[TB] FAIL ror single-cycle valid: got %b expected 0", out_valid8); end
    endtask

    task automatic test_shift_fill();
        logic [7:0] din  [6];
        logic [2:0] sh   [6];
        logic [1:0] md   [6];
        logic [7:0] exp  [6];
        din = '{8'h99, 8'h80, 8'h80, 8'h40, 8'h9A, 8'h5A};
        sh  = '{3'd1,  3'd7,  3'd7,  3'd3,  3'd0,  3'd0};
        md  = '{SRA,   SRA,   SRL,   SRA,   SRA,   ROR};
        exp = '{8'hCC, 8'hFF, 8'h01, 8'h08, 8'h9A, 8'h5A};
        drive8(1'b1, din[0], sh[0], md[0]);
        for (int c = 0; c < 8; c++) begin
            step();
            if (c >= 2) begin
                vectors++; if (out_valid8 !== 1'b1) begin miscompares++; $display("[TB] FAIL fill valid op%0d: got %b expected 1", c-2, out_valid8); end
                vectors++; if (data_out8 !== exp[c-2]) begin miscompares++; $display("[TB] FAIL fill data op%0d: got %h expected %h", c-2, data_out8, exp[c-2]); end
            end else begin
                vectors++; if (out_valid8 !== 1'b0) begin miscompares++; $display("[TB] FAIL fill early valid c%0d: got %b expected 0", c, out_valid8); end
            end
            if (c + 1 < 6) drive8(1'b1, din[c+1], sh[c+1], md[c+1]);
            else           drive8(1'b0, 8'h00, 3'd0, SLL);
        end
        step();
        vectors++; if (out_valid8 !== 1'b0) begin miscompares++; $display("[TB] FAIL fill drained valid: got %b expected 0", out_valid8); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] sh  [4];
        logic [7:0] exp [4];
        sh  = '{3'd0, 3'd1, 3'd2, 3'd7};
        exp = '{8'h01, 8'h02, 8'h04, 8'h80};
        drive8(1'b1, 8'h01, sh[0], SLL);
        for (int c = 0; c < 6; c++) begin
            step();
            vectors++; if (in_ready8 !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b in_ready c%0d: got %b expected 1", c, in_ready8); end
            if (c >= 2) begin
                vectors++; if (out_valid8 !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b valid op%0d: got %b expected 1", c-2, out_valid8); end
                vectors++; if (data_out8 !== exp[c-2]) begin miscompares++; $display("[TB] FAIL b2b data op%0d: got %h expected %h", c-2, data_out8, exp[c-2]); end
            end
            if (c + 1 < 4) drive8(1'b1, 8'h01, sh[c+1], SLL);
            else           drive8(1'b0, 8'h00, 3'd0, SLL);
        end
        step();
        vectors++; if (out_valid8 !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b drained valid: got %b expected 0", out_valid8); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [3];
        exp = '{8'h0C, 8'h0F, 8'hE0};
        drive8(1'b1, 8'h01, 3'd1, ROR);
        step();
        drive8(1'b1, 8'h03, 3'd2, SLL);
        step();
        drive8(1'b1, 8'hF0, 3'd4, SRL);
        step();
        vectors++; if (data_out8 !== 8'h80 || out_valid8 !== 1'b1) begin miscompares++; $display("[TB] FAIL bp head: got valid=%b data=%h expected valid=1 data=80", out_valid8, data_out8); end
        drive8(1'b1, 8'h80, 3'd2, SRA);
        out_ready8 = 1'b0;
        #1;
        vectors++; if (in_ready8 !== 1'b0) begin miscompares++; $display("[TB] FAIL bp in_ready on stall: got %b expected 0", in_ready8); end
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++; if (out_valid8 !== 1'b1) begin miscompares++; $display("[TB] FAIL bp hold valid c%0d: got %b expected 1", i, out_valid8); end
            vectors++; if (data_out8 !== 8'h80) begin miscompares++; $display("[TB] FAIL bp hold data c%0d: got %h expected 80", i, data_out8); end
            vectors++; if (in_ready8 !== 1'b0) begin miscompares++; $display("[TB] FAIL bp hold in_ready c%0d: got %b expected 0", i, in_ready8); end
            vectors++; if (busy8 !== 1'b1) begin miscompares++; $display("[TB] FAIL bp hold busy c%0d: got %b expected 1", i, busy8); end
        end
        out_ready8 = 1'b1;
        #1;
        vectors++; if (in_ready8 !== 1'b1) begin miscompares++; $display("[TB] FAIL bp in_ready on release: got %b expected 1", in_ready8); end
        step();
        drive8(1'b0, 8'h00, 3'd0, SLL);
        for (int i = 0; i < 3; i++) begin
            vectors++; if (out_valid8 !== 1'b1) begin miscompares++; $display("[TB] FAIL bp drain valid op%0d: got %b expected 1", i, out_valid8); end
            vectors++; if (data_out8 !== exp[i]) begin miscompares++; $display("[TB] FAIL bp drain data op%0d: got %h expected %h", i, data_out8, exp[i]); end
            step();
        end
        vectors++; if (out_valid8 !== 1'b0) begin miscompares++; $display("[TB] FAIL bp no duplicate: got %b expected 0", out_valid8); end
    endtask

    task automatic test_flush();
        drive8(1'b1, 8'h01, 3'd1, SLL);
        step();
        drive8(1'b1, 8'h80, 3'd1, SRL);
        step();
        vectors++; if (busy8 !== 1'b1) begin miscompares++; $display("[TB] FAIL flush pre busy: got %b expected 1", busy8); end
        drive8(1'b1, 8'h0F, 3'd2, ROR);
        flush8 = 1'b1;
        #1;
        vectors++; if (in_ready8 !== 1'b1) begin miscompares++; $display("[TB] FAIL flush in_ready: got %b expected 1", in_ready8); end
        step();
        flush8 = 1'b0;
        drive8(1'b0, 8'h00, 3'd0, SLL);
        vectors++; if (busy8 !== 1'b0) begin miscompares++; $display("[TB] FAIL flush busy: got %b expected 0", busy8); end
        vectors++; if (out_valid8 !== 1'b0) begin miscompares++; $display("[TB] FAIL flush valid: got %b expected 0", out_valid8); end
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++; if (out_valid8 !== 1'b0 || busy8 !== 1'b0) begin miscompares++; $display("[TB] FAIL flush ghost c%0d: got valid=%b busy=%b expected 0/0", i, out_valid8, busy8); end
        end
        // Flush while the output is stalled must still empty the pipe.
        drive8(1'b1, 8'h11, 3'd0, SLL);
        step();
        drive8(1'b1, 8'h22, 3'd0, SLL);
        step();
        drive8(1'b1, 8'h33, 3'd0, SLL);
        step();
        drive8(1'b0, 8'h00, 3'd0, SLL);
        out_ready8 = 1'b0;
        flush8 = 1'b1;
        step();
        flush8 = 1'b0;
        vectors++; if (out_valid8 !== 1'b0) begin miscompares++; $display("[TB] FAIL flush-stall valid: got %b expected 0", out_valid8); end
        vectors++; if (busy8 !== 1'b0) begin miscompares++; $display("[TB] FAIL flush-stall busy: got %b expected 0", busy8); end
        vectors++; if (in_ready8 !== 1'b1) begin miscompares++; $display("[TB] FAIL flush-stall in_ready: got %b expected 1", in_ready8); end
        out_ready8 = 1'b1;
    endtask

    task automatic test_reset_mid();
        int lat;
        drive8(1'b1, 8'h01, 3'd3, SLL);
        step();
        drive8(1'b1, 8'h02, 3'd3, SLL);
        step();
        drive8(1'b1, 8'h04, 3'd3, SLL);
        step();
        drive8(1'b0, 8'h00, 3'd0, SLL);
        vectors++; if (out_valid8 !== 1'b1 || data_out8 !== 8'h08) begin miscompares++; $display("[TB] FAIL rst8 pre: got valid=%b data=%h expected 1/08", out_valid8, data_out8); end
        #3;
        reset = 1'b1;
        #1;
        vectors++; if (out_valid8 !== 1'b0) begin miscompares++; $display("[TB] FAIL rst8 async valid: got %b expected 0", out_valid8); end
        vectors++; if (data_out8 !== 8'h00) begin miscompares++; $display("[TB] FAIL rst8 async data: got %h expected 00", data_out8); end
        vectors++; if (busy8 !== 1'b0) begin miscompares++; $display("[TB] FAIL rst8 async busy: got %b expected 0", busy8); end
        vectors++; if (in_ready8 !== 1'b1) begin miscompares++; $display("[TB] FAIL rst8 async in_ready: got %b expected 1", in_ready8); end
        step();
        reset = 1'b0;
        drive8(1'b1, 8'h81, 3'd4, ROR);
        step();
        drive8(1'b0, 8'h00, 3'd0, SLL);
        step();
        vectors++; if (out_valid8 !== 1'b0) begin miscompares++; $display("[TB] FAIL rst8 post early valid: got %b expected 0", out_valid8); end
        step();
        vectors++; if (out_valid8 !== 1'b1 || data_out8 !== 8'h18) begin miscompares++; $display("[TB] FAIL rst8 post op: got valid=%b data=%h expected 1/18", out_valid8, data_out8); end

        in_valid32 = 1'b1; data_in32 = 32'hFFFF0000; shamt32 = 5'd8; mode32 = SRA;
        step();
        in_valid32 = 1'b0;
        step();
        vectors++; if (busy32 !== 1'b1) begin miscompares++; $display("[TB] FAIL rst32 pre busy: got %b expected 1", busy32); end
        #3;
        reset = 1'b1;
        #1;
        vectors++; if (busy32 !== 1'b0 || out_valid32 !== 1'b0 || data_out32 !== 32'h0 || in_ready32 !== 1'b1) begin
            miscompares++; $display("[TB] FAIL rst32 async: got busy=%b valid=%b data=%h ready=%b expected 0/0/00000000/1", busy32, out_valid32, data_out32, in_ready32); end
        step();
        reset = 1'b0;
        in_valid32 = 1'b1; data_in32 = 32'h80000001; shamt32 = 5'd31; mode32 = ROR;
        step();
        in_valid32 = 1'b0;
        lat = 1;
        while (out_valid32 !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        vectors++; if (out_valid32 !== 1'b1) begin miscompares++; $display("[TB] FAIL rst32 timeout: got valid=%b expected 1 within 20 cycles", out_valid32); end
        vectors++; if (lat != 5) begin miscompares++; $display("[TB] FAIL rst32 latency: got %0d expected 5", lat); end
        vectors++; if (data_out32 !== 32'h00000003) begin miscompares++; $display("[TB] FAIL rst32 ror data: got %h expected 00000003", data_out32); end
        step();
        vectors++; if (out_valid32 !== 1'b0) begin miscompares++; $display("[TB] FAIL rst32 single valid: got %b expected 0", out_valid32); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_ror();
        test_shift_fill();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
